// File: rtl/burst_phase_pkg.sv
// Shared types and constants for the burst phase accumulator.
// Optional dither build: PHASE_DITHER_EN.
package burst_phase_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int PHASE_W_DEF = 48;
    localparam int ADDR_W_DEF  = 14;
    localparam int CNT_W_DEF   = 20;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifting left.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/phase_lfsr16.sv
// 16-bit Fibonacci LFSR used as address dither; only built with PHASE_DITHER_EN.
`ifdef PHASE_DITHER_EN
module phase_lfsr16
    import burst_phase_pkg::*;
(
    input  logic        clk_i,
    input  logic        seed_i,
    input  logic        adv_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    // Step once per advancing cycle; feedback is the parity of the tap bits.
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i)
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // Seed load takes priority so every burst restart gets the same sequence.
    always_ff @(posedge clk_i) begin
        if (seed_i) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/burst_phase_accum.sv
// DDS phase accumulator for waveform bursts: finishes the current waveform
// cycle before stopping, reports and counts completed cycles.
// Optional address dither: PHASE_DITHER_EN.
module burst_phase_accum
    import burst_phase_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Pulse_EN,
    input  logic               Pulse_Reset,
    input  logic [PHASE_W-1:0] Freq_Word,
    input  logic               Freq_Load,
    input  logic [PHASE_W-1:0] Start_Phase,
    output logic [ADDR_W-1:0]  Wave_Addr,
    output logic               Addr_Valid,
    output logic               Cycle_Done,
    output logic [CNT_W-1:0]   Cycle_Count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic               pend_q, pend_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               vld_q, vld_d;

    logic [PHASE_W:0]   sum_w;
    logic               running;
    logic               carry;
    logic [PHASE_W-1:0] phase_w;

    assign running = (state_q != IDLE);
    assign sum_w   = {1'b0, acc_q} + {1'b0, freq_q};
    assign carry   = running & sum_w[PHASE_W];

`ifdef PHASE_DITHER_EN
    localparam int DITHER_LSB = PHASE_W - ADDR_W - 16;
    logic [15:0] lfsr_w;

    phase_lfsr16 u_lfsr (
        .clk_i  (Clock),
        .seed_i (Reset | Pulse_Reset),
        .adv_i  (running),
        .lfsr_o (lfsr_w)
    );

    // Dither sits just below the address bits; acc itself never sees it.
    assign phase_w = acc_q + Start_Phase
                   + ({{(PHASE_W-16){1'b0}}, lfsr_w} << DITHER_LSB);
`else
    assign phase_w = acc_q + Start_Phase;
`endif

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            freq_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            freq_q  <= freq_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
        end
    end

    // Next state: accumulate, detect wraps, drain to the end of the cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        freq_d  = freq_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (Pulse_Reset) begin
            // Restart wins over any wrap in the same cycle.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_d  = '0;
                    freq_d = Freq_Word;
                    if (Pulse_EN) state_d = RUN;
                end
                RUN, DRAIN: begin
                    acc_d = sum_w[PHASE_W-1:0];
                    if (carry) begin
                        done_d = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
                        if (pend_q) begin
                            freq_d = Freq_Word;
                            pend_d = 1'b0;
                        end
                        // A wrap with enable low ends the burst right here.
                        if (Pulse_EN) begin
                            state_d = RUN;
                        end else begin
                            state_d = IDLE;
                            acc_d   = '0;
                        end
                    end else if (Pulse_EN) begin
                        state_d = RUN;
                    end else if (state_q == DRAIN && freq_q == '0) begin
                        // Zero step would never wrap; stop without a done pulse.
                        state_d = IDLE;
                        acc_d   = '0;
                    end else begin
                        state_d = DRAIN;
                    end
                    // Lowest priority: a load seen on a wrap waits for the next one.
                    if (Freq_Load) pend_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: address and valid are registered from the current acc/state.
    always_comb begin
        addr_d = phase_w[PHASE_W-1 -: ADDR_W];
        vld_d  = running;
    end

    assign Wave_Addr   = addr_q;
    assign Addr_Valid  = vld_q;
    assign Cycle_Done  = done_q;
    assign Cycle_Count = cnt_q;

endmodule

// File: doc/burst_phase_accum.md
Name: burst_phase_accum

Overview:
Downstream consumer of the burst controller's Pulse_EN/Pulse_Reset outputs. A DDS phase accumulator that produces the waveform-RAM read address while a burst is enabled. It always finishes the current waveform cycle before stopping. It reports each completed cycle, and keeps a completed-cycle count for burst-amount comparison and status readback.

Parameters:
PHASE_W, 48, accumulator and frequency-word width (matches Internal_Period_Value width)
ADDR_W, 14, waveform RAM address width; address = top ADDR_W bits of phase
CNT_W, 20, completed-cycle counter width (matches Amount_Value_in width)

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset  in  1  synchronous, active-high global reset
Pulse_EN  in  1  burst enable from burst controller; level
Pulse_Reset  in  1  burst restart from burst controller; one-cycle pulse, synchronous
Freq_Word  in  PHASE_W  phase increment per clock
Freq_Load  in  1  one-cycle request to adopt Freq_Word phase-continuously
Start_Phase  in  PHASE_W  burst start phase offset
Wave_Addr  out  ADDR_W  waveform RAM read address (registered)
Addr_Valid  out  1  Wave_Addr is live (state RUN or DRAIN)
Cycle_Done  out  1  one-cycle pulse per completed waveform cycle
Cycle_Count  out  CNT_W  completed cycles since last Pulse_Reset; saturating

Behaviour:
- Internal registers: acc (PHASE_W), freq_act (PHASE_W), load_pend, state.
- Reset values:
  - all outputs 0
  - acc = 0
  - freq_act = 0
  - load_pend = 0
  - state = IDLE
- Address: Wave_Addr <= (acc + Start_Phase)[PHASE_W-1 -: ADDR_W], computed modulo 2^PHASE_W. Addr_Valid is registered alongside it, so both lag acc by one cycle.
- States:
  - IDLE: acc held at 0; freq_act <= Freq_Word every cycle. On Pulse_EN=1, go to RUN.
  - RUN: acc <= acc + freq_act. If Pulse_EN=0, go to DRAIN.
  - DRAIN: acc keeps accumulating. On carry-out, go to IDLE and set acc = 0. If Pulse_EN returns to 1 before carry-out, go back to RUN.
- Carry-out of acc + freq_act (in RUN or DRAIN) marks one completed cycle:
  - Cycle_Done = 1 on the following cycle
  - Cycle_Count increments, saturating at 2^CNT_W-1
- Freq_Load while in RUN or DRAIN sets load_pend. At the next carry-out, freq_act <= Freq_Word and load_pend clears. This gives a phase-continuous frequency change.
- freq_act == 0 in DRAIN: go to IDLE next cycle, with no Cycle_Done.
- Pulse_Reset, from any state:
  - acc = 0, Cycle_Count = 0, load_pend = 0, state = IDLE
  - a carry in the same cycle is discarded (no Cycle_Done)
  - if Pulse_EN is still 1, RUN is entered on the following cycle
- Priority: Reset > Pulse_Reset > carry/state logic > Freq_Load.
- Carry-out and Freq_Load in the same cycle: the wrap uses the old freq_act and sets load_pend; the new word is applied at the next wrap.
- Latency: Pulse_EN rising in IDLE gives the first Addr_Valid=1 two cycles later, with the address at Start_Phase.

Optional Feature:
Macro PHASE_DITHER_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reseeded on Reset/Pulse_Reset) advances each RUN/DRAIN cycle. Its value is added at bit positions [PHASE_W-ADDR_W-1 -: 16] of (acc + Start_Phase) before truncation, to spread truncation spurs. The dither never affects acc, carry, Cycle_Done or Cycle_Count.
- Not defined: plain truncation, and no LFSR logic is present.

Decomposition:
- Package burst_phase_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - default widths PHASE_W/ADDR_W/CNT_W
  - LFSR seed and tap constants
- One sub-module: phase_lfsr16 (dither generator), instantiated only under PHASE_DITHER_EN.

Test Plan:
- Freq_Word=2^44, Start_Phase=0, Pulse_EN high for 32 cycles then low -> Wave_Addr steps 0,1024,2048,...; Cycle_Done pulses twice; Cycle_Count=2; returns to IDLE with Addr_Valid=0.
- Same setup, Pulse_EN dropped after 20 cycles -> DRAIN continues to the 32nd increment; Cycle_Count=2; Addr_Valid stays 1 until the wrap.
- Start_Phase=2^47, Freq_Word=2^44 -> first valid Wave_Addr=8192, wrapping through 16383 to 0; Cycle_Done timing identical to the Start_Phase=0 case.
- Pulse_Reset on the exact carry cycle with Cycle_Count=5 -> no Cycle_Done; Cycle_Count=0; acc=0; RUN re-entered next cycle with Pulse_EN held high.
- Freq_Load with Freq_Word=2^45 mid-cycle (freq_act=2^44) -> remaining steps stay at 1024; after the wrap, steps are 2048 and cycles take 8 clocks.
- Cycle_Count preset near saturation via 2^20+3 cycles at Freq_Word=2^47 -> Cycle_Count holds 20'hFFFFF.
